// File: rtl/rx_tmp_buf_slab_alloc.sv
// Free-bitmap slab allocator for RX temporary buffers: one lowest-index grant
// port and two free ports (commit and drop) that are consumed in the cycle presented.
module rx_tmp_buf_slab_alloc #(
  parameter int NUM_SLABS    = 10,
  parameter int SLAB_BYTES   = 2048,
  parameter int LOW_WM       = 2,
  parameter int SLAB_NUM_W   = $clog2(NUM_SLABS),
  parameter int SLAB_BYTES_W = $clog2(SLAB_BYTES),
  parameter int CNT_W        = $clog2(NUM_SLABS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                src_alloc_req_val,
  output logic                                alloc_src_req_rdy,
  output logic [SLAB_NUM_W-1:0]               alloc_src_resp_slab,
  output logic [SLAB_NUM_W+SLAB_BYTES_W-1:0]  alloc_src_resp_addr,
  input  logic                                src_free0_val,
  input  logic [SLAB_NUM_W-1:0]               src_free0_slab,
  input  logic                                src_free1_val,
  input  logic [SLAB_NUM_W-1:0]               src_free1_slab,
  output logic [CNT_W-1:0]                    free_cnt,
  output logic                                low_wm,
  output logic                                err_free
);

  logic [NUM_SLABS-1:0] bitmap_reg;
  logic [NUM_SLABS-1:0] bitmap_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic                 err_reg;
  logic                 err_next;

  logic [NUM_SLABS-1:0] grant_onehot;
  logic [SLAB_NUM_W-1:0] grant_slab;
  logic                 grant;

  logic [NUM_SLABS-1:0] dec0;
  logic [NUM_SLABS-1:0] dec1;
  logic [NUM_SLABS-1:0] set0;
  logic [NUM_SLABS-1:0] set1;
  logic                 same_slab;
  logic                 acc0;
  logic                 acc1;

  // Decoding against the slab range means an out-of-range number never hits a bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLABS; gi++) begin : g_dec
      assign dec0[gi] = (src_free0_slab == SLAB_NUM_W'(gi));
      assign dec1[gi] = (src_free1_slab == SLAB_NUM_W'(gi));
    end
  endgenerate

  // Lowest-index set bit of the registered bitmap.
  always_comb begin
    grant_onehot = '0;
    grant_slab   = '0;
    for (int i = NUM_SLABS - 1; i >= 0; i--) begin
      if (bitmap_reg[i]) begin
        grant_onehot = '0;
        grant_onehot[i] = 1'b1;
        grant_slab   = SLAB_NUM_W'(i);
      end
    end
  end

  assign alloc_src_req_rdy   = |bitmap_reg;
  assign alloc_src_resp_slab = grant_slab;
  assign alloc_src_resp_addr = {grant_slab, {SLAB_BYTES_W{1'b0}}};
  assign grant               = src_alloc_req_val & alloc_src_req_rdy;

  // A free is only accepted for an allocated slab; a duplicate on port 1 is
  // refused so the bit is set (and counted) once.
  assign same_slab = src_free0_val & src_free1_val & (src_free0_slab == src_free1_slab);
  assign acc0      = src_free0_val & |(dec0 & ~bitmap_reg);
  assign acc1      = src_free1_val & |(dec1 & ~bitmap_reg) & ~same_slab;
  assign set0      = acc0 ? dec0 : '0;
  assign set1      = acc1 ? dec1 : '0;

  always_comb begin
    bitmap_next = (bitmap_reg & ~(grant ? grant_onehot : '0)) | set0 | set1;
    cnt_next    = cnt_reg + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(grant);
    err_next    = (src_free0_val & ~acc0) | (src_free1_val & ~acc1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_reg <= '1;
      cnt_reg    <= CNT_W'(NUM_SLABS);
      err_reg    <= 1'b0;
    end else begin
      bitmap_reg <= bitmap_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
    end
  end

  assign free_cnt = cnt_reg;
  assign low_wm   = (cnt_reg <= CNT_W'(LOW_WM));
  assign err_free = err_reg;

endmodule

// File: tb/tb_rx_tmp_buf_slab_alloc.sv
// Directed bench for the slab allocator; each task checks one scenario
// against hand-computed expectations.
module tb_rx_tmp_buf_slab_alloc;

  logic        clk;
  logic        rst;
  logic        src_alloc_req_val;
  logic        alloc_src_req_rdy;
  logic [3:0]  alloc_src_resp_slab;
  logic [14:0] alloc_src_resp_addr;
  logic        src_free0_val;
  logic [3:0]  src_free0_slab;
  logic        src_free1_val;
  logic [3:0]  src_free1_slab;
  logic [3:0]  free_cnt;
  logic        low_wm;
  logic        err_free;

  int checks = 0;
  int errors = 0;

  rx_tmp_buf_slab_alloc dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_alloc_req_val   (src_alloc_req_val),
    .alloc_src_req_rdy   (alloc_src_req_rdy),
    .alloc_src_resp_slab (alloc_src_resp_slab),
    .alloc_src_resp_addr (alloc_src_resp_addr),
    .src_free0_val       (src_free0_val),
    .src_free0_slab      (src_free0_slab),
    .src_free1_val       (src_free1_val),
    .src_free1_slab      (src_free1_slab),
    .free_cnt            (free_cnt),
    .low_wm              (low_wm),
    .err_free            (err_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_alloc_req_val = 1'b0;
    src_free0_val     = 1'b0;
    src_free1_val     = 1'b0;
    src_free0_slab    = 4'd0;
    src_free1_slab    = 4'd0;
  endtask

  task automatic check_state(input string name, input logic exp_rdy, input logic [3:0] exp_slab,
                             input logic [3:0] exp_cnt, input logic exp_low, input logic exp_err);
    checks++;
    if (alloc_src_req_rdy !== exp_rdy || alloc_src_resp_slab !== exp_slab ||
        free_cnt !== exp_cnt || low_wm !== exp_low || err_free !== exp_err) begin
      errors++;
      $display("FAIL %s: rdy=%b slab=%0d cnt=%0d low=%b err=%b required rdy=%b slab=%0d cnt=%0d low=%b err=%b",
               name, alloc_src_req_rdy, alloc_src_resp_slab, free_cnt, low_wm, err_free,
               exp_rdy, exp_slab, exp_cnt, exp_low, exp_err);
    end else begin
      $display("ok   %s: rdy=%b slab=%0d cnt=%0d low=%b err=%b",
               name, alloc_src_req_rdy, alloc_src_resp_slab, free_cnt, low_wm, err_free);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 1'b1, 4'd0, 4'd10, 1'b0, 1'b0);
    checks++;
    if (alloc_src_resp_addr !== 15'h0000) begin
      errors++;
      $display("FAIL reset_addr: got 0x%04h required 0x0000", alloc_src_resp_addr);
    end
  endtask

  task automatic test_alloc_all();
    logic [14:0] exp_addr;
    for (int i = 0; i < 10; i++) begin
      src_alloc_req_val = 1'b1;
      exp_addr = 15'(i) << 11;
      check_state($sformatf("grant_%0d", i), 1'b1, 4'(i), 4'(10 - i), (10 - i) <= 2, 1'b0);
      checks++;
      if (alloc_src_resp_addr !== exp_addr) begin
        errors++;
        $display("FAIL grant_addr_%0d: got 0x%04h required 0x%04h", i, alloc_src_resp_addr, exp_addr);
      end
      tick();
    end
    idle();
    check_state("all_allocated", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    // val without rdy must not disturb anything
    src_alloc_req_val = 1'b1;
    tick();
    check_state("val_no_rdy", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_free_one();
    src_free0_val  = 1'b1;
    src_free0_slab = 4'd5;
    tick();
    idle();
    check_state("free0_slab5", 1'b1, 4'd5, 4'd1, 1'b1, 1'b0);
  endtask

  task automatic test_alloc_free_same();
    src_free1_val  = 1'b1;
    src_free1_slab = 4'd0;
    tick();
    idle();
    check_state("free1_slab0", 1'b1, 4'd0, 4'd2, 1'b1, 1'b0);
    // grant 0 while slab 3 returns; slab 3 only grantable afterwards
    src_alloc_req_val = 1'b1;
    src_free1_val     = 1'b1;
    src_free1_slab    = 4'd3;
    check_state("alloc_with_free_pre", 1'b1, 4'd0, 4'd2, 1'b1, 1'b0);
    tick();
    idle();
    check_state("alloc_with_free_post", 1'b1, 4'd3, 4'd2, 1'b1, 1'b0);
  endtask

  task automatic test_illegal_free();
    src_free0_val  = 1'b1;
    src_free0_slab = 4'd7;
    tick();
    check_state("free7_legal", 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    tick();
    idle();
    check_state("free7_again", 1'b1, 4'd3, 4'd3, 1'b0, 1'b1);
    tick();
    check_state("err_clears", 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    src_free1_val  = 1'b1;
    src_free1_slab = 4'd12;
    tick();
    idle();
    check_state("free_out_of_range", 1'b1, 4'd3, 4'd3, 1'b0, 1'b1);
    // freeing the slab being granted: error, grant still clears it
    src_alloc_req_val = 1'b1;
    src_free0_val     = 1'b1;
    src_free0_slab    = 4'd3;
    tick();
    idle();
    check_state("free_granted_slab", 1'b1, 4'd5, 4'd2, 1'b1, 1'b1);
  endtask

  task automatic test_dup_free();
    src_free0_val  = 1'b1;
    src_free0_slab = 4'd4;
    src_free1_val  = 1'b1;
    src_free1_slab = 4'd4;
    tick();
    idle();
    check_state("dup_free_slab4", 1'b1, 4'd4, 4'd3, 1'b0, 1'b1);
    // two distinct allocated slabs freed together
    src_free0_val  = 1'b1;
    src_free0_slab = 4'd9;
    src_free1_val  = 1'b1;
    src_free1_slab = 4'd1;
    tick();
    idle();
    check_state("dual_free_1_9", 1'b1, 4'd1, 4'd5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      src_alloc_req_val = 1'b1;
      tick();
    end
    idle();
    check_state("six_allocated", 1'b1, 4'd6, 4'd4, 1'b0, 1'b0);
    rst               = 1'b1;
    src_alloc_req_val = 1'b1;
    src_free0_val     = 1'b1;
    src_free0_slab    = 4'd12;
    tick();
    rst = 1'b0;
    idle();
    check_state("reset_mid", 1'b1, 4'd0, 4'd10, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_alloc_all();
    test_free_one();
    test_alloc_free_same();
    test_illegal_free();
    test_dup_free();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_tmp_buf_slab_alloc.md
RX_TMP_BUF_SLAB_ALLOC -- requirements
Module: rx_tmp_buf_slab_alloc

Interface
REQ-001 SHALL have parameter NUM_SLABS, default 10, number of RX temp-buffer slabs managed.
REQ-002 SHALL have parameter SLAB_BYTES, default 2048, bytes per slab (power of two).
REQ-003 SHALL have parameter LOW_WM, default 2, free-count low-watermark threshold.
REQ-004 SHALL derive SLAB_NUM_W = $clog2(NUM_SLABS), SLAB_BYTES_W = $clog2(SLAB_BYTES), CNT_W = $clog2(NUM_SLABS+1).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 src_alloc_req_val  in  1  requester wants one slab.
REQ-008 alloc_src_req_rdy  out  1  a slab is available this cycle.
REQ-009 alloc_src_resp_slab  out  SLAB_NUM_W  granted slab number, valid when val&rdy.
REQ-010 alloc_src_resp_addr  out  SLAB_NUM_W+SLAB_BYTES_W  byte base address of granted slab.
REQ-011 src_free0_val / src_free0_slab  in  1 / SLAB_NUM_W  free port 0 (commit path).
REQ-012 src_free1_val / src_free1_slab  in  1 / SLAB_NUM_W  free port 1 (drop path).
REQ-013 free_cnt  out  CNT_W  number of currently free slabs.
REQ-014 low_wm  out  1  free_cnt <= LOW_WM.
REQ-015 err_free  out  1  one-cycle pulse on illegal free.

Function
REQ-016 SHALL hold a NUM_SLABS-bit registered free bitmap; bit i = 1 means slab i is free.
REQ-017 alloc_src_req_rdy SHALL be the OR of the bitmap (combinational from registers, independent of val).
REQ-018 alloc_src_resp_slab SHALL be the lowest-index set bit of the registered bitmap, combinational, zero latency.
REQ-019 alloc_src_resp_addr SHALL equal alloc_src_resp_slab concatenated with SLAB_BYTES_W zero bits.
REQ-020 On val&rdy the granted bit SHALL clear at the next edge; val without rdy SHALL have no effect and the requester holds val.
REQ-021 Free ports SHALL have no rdy; every free is consumed in the cycle presented.
REQ-022 A free of slab s < NUM_SLABS whose bit is 0 SHALL set bit s at the next edge.
REQ-023 A free of a slab already free (bit 1) or s >= NUM_SLABS SHALL leave the bitmap unchanged and pulse err_free next cycle.
REQ-024 Both free ports naming the same slab in one cycle SHALL set the bit once and pulse err_free.
REQ-025 Both free ports naming different legal allocated slabs in one cycle SHALL set both bits.
REQ-026 Alloc and free in the same cycle SHALL both take effect; alloc uses the pre-update bitmap, so a slab freed this cycle is not grantable until the next cycle.
REQ-027 Freeing the slab being granted in the same cycle is illegal (bit is 1); it SHALL pulse err_free, and the grant clears the bit.
REQ-028 free_cnt SHALL be a registered counter updated as count + frees_accepted - alloc_accepted, matching bitmap popcount every cycle; no wrap.
REQ-029 low_wm SHALL be combinational from registered free_cnt.

Reset
REQ-030 While rst is high at an edge: bitmap all ones (NUM_SLABS bits), free_cnt = NUM_SLABS, err_free = 0; alloc/free inputs ignored.
REQ-031 After reset: alloc_src_req_rdy = 1, alloc_src_resp_slab = 0, low_wm = 0 (default params).
REQ-032 Reset asserted mid-operation SHALL discard all outstanding allocations in the same edge.

Verification
REQ-033 Reset, then 10 consecutive val cycles -> grants slabs 0..9 with addrs 0x0000..0x4800; free_cnt 10->0; low_wm rises when free_cnt = 2; rdy = 0 after 10th grant.
REQ-034 All allocated, free0 slab 5 -> next cycle rdy = 1, resp_slab = 5, free_cnt = 1.
REQ-035 Alloc slab 0 while free1 frees slab 3 (allocated) in same cycle -> grant 0, next cycle slab 3 free, free_cnt unchanged net.
REQ-036 free0 slab 7 when already free, then free1 slab 12 -> err_free pulses each time, bitmap and free_cnt unchanged.
REQ-037 free0 and free1 both slab 4 (allocated) same cycle -> bit 4 set once, free_cnt +1, err_free pulse.
REQ-038 Allocate 6 slabs, assert rst one cycle -> free_cnt = 10, resp_slab = 0, err_free = 0.
